// File: rtl/uart_tx_core_if.sv
// UART transmitter request/line bundle.
// The producer (master) drives tx_en/din and watches busy_tx; the transmitter
// (slave) drives the serial line sout and busy_tx.
interface uart_tx_core_if;
    logic       tx_en;
    logic [7:0] din;
    logic       sout;
    logic       busy_tx;

    modport master (output tx_en, output din, input sout, input busy_tx);
    modport slave  (input tx_en, input din, output sout, output busy_tx);
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter core: one byte per request, LSB first, idle-high line.
// Default framing is 8N1. Defining UART_TX_PARITY_EN inserts an even parity
// bit after the data bits (8E1).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, not busy, waiting for tx_en
// S_START  | start bit (low) for CLKS_PER_BIT cycles
// S_DATA   | 8 data bits, LSB first, each CLKS_PER_BIT cycles
// S_PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// S_STOP   | stop bit (high); busy_tx drops on the edge back into S_IDLE
module uart_tx_core #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic          fpga_clk,
    input  logic          nrst,
    uart_tx_core_if.slave tx_if
);

    localparam int unsigned      DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that sout/busy_tx come straight from flops.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        sout_d    = sout_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_end   = (div_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                sout_d    = 1'b1;
                busy_d    = 1'b0;
                div_d     = '0;
                bit_idx_d = '0;
                if (tx_if.tx_en) begin
                    shift_d = tx_if.din;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_if.din;
`endif
                    state_d = S_START;
                    sout_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    div_d     = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    sout_d    = shift_q[0];
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        sout_d  = parity_q;
`else
                        state_d = S_STOP;
                        sout_d  = 1'b1;
`endif
                    end else begin
                        // shift register always presents the current bit at [0]
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        sout_d    = shift_q[1];
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = S_STOP;
                    sout_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                    sout_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                sout_d  = 1'b1;
                busy_d  = 1'b0;
                div_d   = '0;
            end
        endcase
    end

    // FSM and output registers; reset aborts any frame and parks the line high.
    always_ff @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            sout_q    <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            sout_q    <= sout_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_if.sout    = sout_q;
    assign tx_if.busy_tx = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: directed frames plus random bytes, random gaps and
// random mid-frame tx_en/din activity, checked cycle by cycle against a frame
// model built from the serial framing rules.
module tb_uart_tx_core;

    localparam int C = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int M_HOLD  = 0;
    localparam int M_PULSE = 1;
    localparam int M_RAND  = 2;

    logic clk;
    logic nrst;
    int   n_vec = 0;
    int   n_err = 0;

    uart_tx_core_if u_if ();

    uart_tx_core #(.CLKS_PER_BIT(C)) dut (
        .fpga_clk (clk),
        .nrst     (nrst),
        .tx_if    (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Serial bit k of the frame for byte b: start, data LSB first, [parity], stop.
    function automatic logic ref_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    // Called just after an edge with the DUT idle: drive tx_en low for n cycles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            u_if.tx_en = 1'b0;
            u_if.din   = 8'($urandom);
            @(negedge clk);
            chk("idle_sout", 32'(u_if.sout), 32'd1);
            chk("idle_busy", 32'(u_if.busy_tx), 32'd0);
            @(posedge clk);
        end
    endtask

    // Called just after an edge with the DUT idle: raise a request for b.
    task automatic request(input logic [7:0] b);
        #1;
        u_if.tx_en = 1'b1;
        u_if.din   = b;
        @(negedge clk);
        chk("gap_sout", 32'(u_if.sout), 32'd1);
        chk("gap_busy", 32'(u_if.busy_tx), 32'd0);
    endtask

    // Capture edge plus the whole frame; ends on the edge that re-enters idle.
    task automatic frame(input logic [7:0] b, input int mode, input int chg_at, input int abort_at);
        int busy_cnt = 0;
        @(posedge clk);
        for (int j = 0; j < NB*C; j++) begin
            #1;
            if (mode == M_PULSE && j == 0) u_if.tx_en = 1'b0;
            if (mode == M_RAND) begin
                u_if.tx_en = 1'($urandom_range(0, 1));
                u_if.din   = 8'($urandom);
            end
            if (j == chg_at) u_if.din = 8'hF0;
            @(negedge clk);
            chk("sout", 32'(u_if.sout), 32'(ref_bit(b, j / C)));
            chk("busy_tx", 32'(u_if.busy_tx), 32'd1);
            if (u_if.busy_tx) busy_cnt++;
            if (j == abort_at) begin
                #2 nrst = 1'b0;
                #1;
                chk("abort_sout", 32'(u_if.sout), 32'd1);
                chk("abort_busy", 32'(u_if.busy_tx), 32'd0);
                return;
            end
            @(posedge clk);
        end
        chk("busy_len", 32'(busy_cnt), 32'(NB*C));
    endtask

    initial begin
        logic [7:0] b;
        nrst       = 1'b0;
        u_if.tx_en = 1'b0;
        u_if.din   = 8'h00;

        // reset held: line idle
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_sout", 32'(u_if.sout), 32'd1);
            chk("rst_busy", 32'(u_if.busy_tx), 32'd0);
        end
        nrst = 1'b1;
        @(posedge clk);
        idle(4);

        // single one-cycle request
        request(8'hEE);
        frame(8'hEE, M_PULSE, -1, -1);
        idle(3);

        // held request: back-to-back frames with a single idle cycle
        request(8'hEE);
        frame(8'hEE, M_HOLD, -1, -1);
        request(8'hEE);
        frame(8'hEE, M_PULSE, -1, -1);
        idle(2);

        // din changes to 0xF0 during data bit 3
        request(8'h95);
        frame(8'h95, M_PULSE, 4*C, -1);
        idle(2);

        // parity-sensitive byte
        request(8'h01);
        frame(8'h01, M_PULSE, -1, -1);
        idle(1);

        // asynchronous abort during data bits
        request(8'h95);
        frame(8'h95, M_PULSE, -1, 5*C + 2);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_sout", 32'(u_if.sout), 32'd1);
            chk("rst_hold_busy", 32'(u_if.busy_tx), 32'd0);
        end
        nrst = 1'b1;
        @(posedge clk);
        idle(2);
        request(8'hF0);
        frame(8'hF0, M_PULSE, -1, -1);

        // random bytes, random gaps, random activity on tx_en/din while busy
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom);
            request(b);
            frame(b, M_RAND, -1, -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
